// File: rtl/ct_lsu_dcache_tag_arb.sv
// ---------------------------------------------------------------------------
// ct_lsu_dcache_tag_arb
//
// Access controller for the L1 dcache tag SRAM. The SRAM word holds two ways
// of 26 bits each: way1 is in [51:26] and way0 is in [25:0].
//
// Each cycle at most one requester gets the tag port. Fixed priority is
// linefill write > snoop read > {load read, store read}. Load and store
// share a round-robin pointer. The block also owns the invalidate sweep,
// which writes zero to every set after reset or on a CP0 invalidate-all.
//
// Optional feature macro: LSU_DCACHE_TAG_INIT_EN
//   defined   : the INIT sweep runs after reset and on cp0 inv_all.
//   undefined : the block comes out of reset in IDLE with init_done=1.
//               inv_all is ignored, inv_done is tied low, and no counter
//               logic is built.
//
// Ports
//   forever_cpuclk, cpurst        clock, async active-high reset
//   cp0_lsu_dcache_inv_all        pulse: invalidate all tags
//   lfb_tag_*                     linefill write req/gnt/idx/din/wen
//   snq_tag_*, ld_tag_*, st_tag_* read req/gnt/idx
//   tag_dout                      SRAM read data
//   tag_sel_b, tag_gwen_b,
//   tag_wen_b, tag_idx, tag_din   SRAM controls (select/writes active-low)
//   tag_gateclk_en                SRAM clock-gate enable
//   tag_rd_vld, tag_rd_src        registered read return (0 ld, 1 st, 2 snq)
//   tag_rd_data                   tag_dout passed through
//   dcache_tag_init_done          high when no sweep is in progress
//   dcache_tag_inv_done           pulse when a CP0 sweep completes
// ---------------------------------------------------------------------------
module ct_lsu_dcache_tag_arb #(
  parameter int TAG_DEPTH = 512,
  parameter int IDX_W     = 9
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             cp0_lsu_dcache_inv_all,
  input  logic             lfb_tag_req,
  output logic             lfb_tag_gnt,
  input  logic [IDX_W-1:0] lfb_tag_idx,
  input  logic [51:0]      lfb_tag_din,
  input  logic [1:0]       lfb_tag_wen,
  input  logic             snq_tag_req,
  output logic             snq_tag_gnt,
  input  logic [IDX_W-1:0] snq_tag_idx,
  input  logic             ld_tag_req,
  output logic             ld_tag_gnt,
  input  logic [IDX_W-1:0] ld_tag_idx,
  input  logic             st_tag_req,
  output logic             st_tag_gnt,
  input  logic [IDX_W-1:0] st_tag_idx,
  input  logic [51:0]      tag_dout,
  output logic             tag_sel_b,
  output logic             tag_gwen_b,
  output logic [1:0]       tag_wen_b,
  output logic [IDX_W-1:0] tag_idx,
  output logic [51:0]      tag_din,
  output logic             tag_gateclk_en,
  output logic             tag_rd_vld,
  output logic [1:0]       tag_rd_src,
  output logic [51:0]      tag_rd_data,
  output logic             dcache_tag_init_done,
  output logic             dcache_tag_inv_done
);

  // sweep_wr: the sweep owns the SRAM this cycle.
  // arb_en:   requesters may be granted this cycle.
  logic             sweep_wr;
  logic             arb_en;
  logic             sweep_busy;
  logic [IDX_W-1:0] sweep_idx;

  // rr_st set means the store side is favoured on the next ld/st tie.
  logic             rr_st;
  logic             rd_gnt;
  logic [IDX_W-1:0] idx_q;
  logic [51:0]      din_q;

`ifdef LSU_DCACHE_TAG_INIT_EN

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

  localparam logic [IDX_W:0] LAST_SET = (IDX_W+1)'(TAG_DEPTH - 1);

  state_t         state;
  logic [IDX_W:0] counter;
  logic           inv_pend;
  logic           init_done_q;
  logic           inv_done_q;

  // Sweep FSM. inv_pend remembers that the current sweep came from CP0 so
  // only that kind of sweep produces the inv_done pulse. An inv_all during
  // INIT restarts the sweep from set 0 instead of finishing it.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state       <= INIT;
      counter     <= '0;
      inv_pend    <= 1'b0;
      init_done_q <= 1'b0;
      inv_done_q  <= 1'b0;
    end else begin
      inv_done_q <= 1'b0;
      if (state == INIT) begin
        if (cp0_lsu_dcache_inv_all) begin
          counter  <= '0;
          inv_pend <= 1'b1;
        end else if (counter == LAST_SET) begin
          state       <= IDLE;
          counter     <= '0;
          init_done_q <= 1'b1;
          inv_done_q  <= inv_pend;
          inv_pend    <= 1'b0;
        end else begin
          counter <= counter + 1'b1;
        end
      end else if (cp0_lsu_dcache_inv_all) begin
        state       <= INIT;
        counter     <= '0;
        inv_pend    <= 1'b1;
        init_done_q <= 1'b0;
      end
    end
  end

  assign sweep_busy           = (state == INIT);
  assign sweep_wr             = sweep_busy & ~cpurst;
  assign arb_en               = (state == IDLE) & ~cpurst;
  assign sweep_idx            = counter[IDX_W-1:0];
  assign dcache_tag_init_done = init_done_q;
  assign dcache_tag_inv_done  = inv_done_q;

`else

  logic init_done_q;
  logic unused_cfg;

  // Without the sweep the tags are declared ready straight out of reset.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      init_done_q <= 1'b1;
    end else begin
      init_done_q <= 1'b1;
    end
  end

  assign sweep_busy           = 1'b0;
  assign sweep_wr             = 1'b0;
  assign arb_en               = ~cpurst;
  assign sweep_idx            = '0;
  assign dcache_tag_init_done = init_done_q;
  assign dcache_tag_inv_done  = 1'b0;
  assign unused_cfg           = cp0_lsu_dcache_inv_all | (TAG_DEPTH == 0);

`endif

  // Fixed priority lfb > snq, then ld/st round-robin when both ask.
  assign lfb_tag_gnt = arb_en & lfb_tag_req;
  assign snq_tag_gnt = arb_en & ~lfb_tag_req & snq_tag_req;
  assign ld_tag_gnt  = arb_en & ~lfb_tag_req & ~snq_tag_req & ld_tag_req
                     & (~st_tag_req | ~rr_st);
  assign st_tag_gnt  = arb_en & ~lfb_tag_req & ~snq_tag_req & st_tag_req
                     & (~ld_tag_req | rr_st);
  assign rd_gnt      = snq_tag_gnt | ld_tag_gnt | st_tag_gnt;

  // SRAM control mux. With no access, idx/din keep their last driven value
  // so the address and data pins do not toggle needlessly.
  always_comb begin
    tag_sel_b  = 1'b1;
    tag_gwen_b = 1'b1;
    tag_wen_b  = 2'b11;
    tag_idx    = idx_q;
    tag_din    = din_q;
    if (sweep_wr) begin
      tag_sel_b  = 1'b0;
      tag_gwen_b = 1'b0;
      tag_wen_b  = 2'b00;
      tag_idx    = sweep_idx;
      tag_din    = '0;
    end else if (lfb_tag_gnt) begin
      tag_sel_b  = 1'b0;
      tag_gwen_b = 1'b0;
      tag_wen_b  = ~lfb_tag_wen;
      tag_idx    = lfb_tag_idx;
      tag_din    = lfb_tag_din;
    end else if (snq_tag_gnt) begin
      tag_sel_b = 1'b0;
      tag_idx   = snq_tag_idx;
    end else if (ld_tag_gnt) begin
      tag_sel_b = 1'b0;
      tag_idx   = ld_tag_idx;
    end else if (st_tag_gnt) begin
      tag_sel_b = 1'b0;
      tag_idx   = st_tag_idx;
    end
  end

  // Hold registers behind the idle value of the address and data pins.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      idx_q <= '0;
      din_q <= '0;
    end else begin
      if (!tag_sel_b) begin
        idx_q <= tag_idx;
      end
      if (!tag_gwen_b) begin
        din_q <= tag_din;
      end
    end
  end

  // Read return one cycle after grant, plus the ld/st round-robin pointer,
  // which flips to the opposite side of whichever of the two was granted.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      tag_rd_vld <= 1'b0;
      tag_rd_src <= 2'd0;
      rr_st      <= 1'b0;
    end else begin
      tag_rd_vld <= rd_gnt;
      if (rd_gnt) begin
        tag_rd_src <= snq_tag_gnt ? 2'd2 : (st_tag_gnt ? 2'd1 : 2'd0);
      end
      if (ld_tag_gnt) begin
        rr_st <= 1'b1;
      end else if (st_tag_gnt) begin
        rr_st <= 1'b0;
      end
    end
  end

  assign tag_gateclk_en = sweep_busy | lfb_tag_req | snq_tag_req
                        | ld_tag_req | st_tag_req;
  assign tag_rd_data    = tag_dout;

endmodule

// File: doc/ct_lsu_dcache_tag_arb.md
# ct_lsu_dcache_tag_arb

Access controller for the L1 dcache tag SRAM (2 ways × 26 bits, 52-bit word). Each cycle it grants at most one tag-array port among four requesters: linefill write, snoop read, load-pipe read and store-pipe read. It also owns the invalidate sweep that clears every tag after reset or on a CP0 invalidate-all. It drives the tag array's active-low select, global-write and per-way write strobes, and returns read data with a one-cycle-delayed valid tagged by source.

## Interface
Parameters:
- TAG_DEPTH, 512, number of tag sets (256 for a 32K cache, 512 for a 64K cache).
- IDX_W, 9, index width; TAG_DEPTH = 2^IDX_W.

Ports:
- forever_cpuclk  in  1  clock.
- cpurst  in  1  reset, asynchronous, active-high.
- cp0_lsu_dcache_inv_all  in  1  pulse: invalidate all tags.
- lfb_tag_req / lfb_tag_gnt  in / out  1  linefill write request / grant.
- lfb_tag_idx  in  IDX_W  linefill write set index.
- lfb_tag_din  in  52  write data ([51:26] way1, [25:0] way0).
- lfb_tag_wen  in  2  active-high way write enables.
- snq_tag_req / snq_tag_gnt  in / out  1  snoop read request / grant.
- snq_tag_idx  in  IDX_W  snoop read index.
- ld_tag_req / ld_tag_gnt  in / out  1  load read request / grant.
- ld_tag_idx  in  IDX_W  load read index.
- st_tag_req / st_tag_gnt  in / out  1  store read request / grant.
- st_tag_idx  in  IDX_W  store read index.
- tag_dout  in  52  SRAM read data.
- tag_sel_b, tag_gwen_b  out  1  SRAM chip select and global write enable, both active-low.
- tag_wen_b  out  2  per-way write enables, active-low.
- tag_idx  out  IDX_W  SRAM address.
- tag_din  out  52  SRAM write data.
- tag_gateclk_en  out  1  SRAM clock-gate enable.
- tag_rd_vld  out  1  read data valid; registered.
- tag_rd_src  out  2  read owner: 0 = ld, 1 = st, 2 = snq; registered.
- tag_rd_data  out  52  tag_dout, passed through.
- dcache_tag_init_done  out  1  high when no sweep is in progress; registered.
- dcache_tag_inv_done  out  1  one-cycle pulse when a CP0-triggered sweep completes.

## Operation
- State machine states: INIT and IDLE.
- Reset enters INIT with sweep counter = 0.
- INIT:
  - Each cycle writes 52'b0 to set `counter`: tag_sel_b=0, tag_gwen_b=0, tag_wen_b=2'b00.
  - All grants are low.
  - When counter = TAG_DEPTH-1 the write completes and the FSM goes to IDLE. dcache_tag_init_done rises the following cycle.
- IDLE, fixed priority: lfb > snq > {ld, st}.
  - ld and st are round-robin arbitrated: the pointer toggles to the other side after each ld or st grant. After reset it favours ld.
- Grants are combinational in the request cycle. The SRAM controls come from the same arbitration result.
  - Write: gwen_b=0, wen_b=~lfb_tag_wen, din=lfb_tag_din.
  - Read: gwen_b=1, wen_b=2'b11.
  - No grant: sel_b=1, gwen_b=1, wen_b=2'b11, idx/din held at their last value.
- Read grant in cycle N gives tag_rd_vld=1 with the matching tag_rd_src in cycle N+1. tag_rd_data is valid that same cycle.
- A requester holds req and idx until granted. Dropping req before grant is legal and has no effect.
- cp0_lsu_dcache_inv_all seen in IDLE:
  - Moves to INIT with counter = 0 and drops dcache_tag_init_done.
  - A read granted in the previous cycle still returns its valid.
  - dcache_tag_inv_done pulses on completion.
- cp0_lsu_dcache_inv_all seen in INIT restarts the counter at 0.
- Counter is IDX_W+1 bits. It never wraps past TAG_DEPTH-1.
- tag_gateclk_en = INIT | any req.

## Timing
- Reset values: tag_rd_vld=0, tag_rd_src=0, dcache_tag_init_done=0, dcache_tag_inv_done=0, rr pointer=ld, counter=0.
- While cpurst is high: tag_sel_b=1, tag_gwen_b=1, tag_wen_b=2'b11, all grants 0. The sweep starts in the first cycle after deassertion.
- cpurst asserted mid-sweep or mid-read: the sweep aborts, tag_rd_vld clears asynchronously, and the sweep restarts from 0 after release.
- Sweep length is TAG_DEPTH cycles. dcache_tag_init_done rises TAG_DEPTH+1 cycles after reset release.
- Read latency is 1 cycle from grant. Write completes in the grant cycle.
- Back-to-back grants are allowed every cycle.

## Configuration
- LSU_DCACHE_TAG_INIT_EN:
  - Defined: the INIT sweep runs after reset and on inv_all, as described above.
  - Undefined:
    - The FSM resets to IDLE and dcache_tag_init_done resets to 1.
    - cp0_lsu_dcache_inv_all is ignored; dcache_tag_inv_done is tied 0.
    - No counter logic is generated. Tag clearing is left to software.

## Test plan
- Reset release, TAG_DEPTH=512 -> 512 consecutive writes, idx 0..511, din=0, wen_b=00. dcache_tag_init_done=1 at cycle 513. No grant during the sweep.
- lfb, snq, ld, st all requesting in the same cycle -> lfb_tag_gnt only, gwen_b=0, wen_b=~lfb_tag_wen (e.g. wen 2'b01 -> 2'b10). The next cycle grants snq.
- ld and st requesting continuously -> grants alternate ld, st, ld, st. tag_rd_src is 0,1,0,1 one cycle later.
- ld read at idx 0x1A5 with tag_dout=52'hABCDE in the next cycle -> tag_idx=0x1A5, gwen_b=1. Next cycle: tag_rd_vld=1, src=0, data=52'hABCDE.
- inv_all pulse while ld is requesting -> ld grant blocked for 512 cycles, dcache_tag_inv_done pulses once, then the ld grant resumes.
- cpurst asserted at sweep idx 200 -> strobes inactive immediately. The sweep restarts at idx 0 after release.
